// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds the PC, requests one word per instruction and
// presents it to the decoder until the datapath retires it.
// Latency: 1 cycle from imem_ready to instr_valid; next request 1 cycle after exec_done.
// Backpressure: imem_req/imem_addr are held until imem_ready; instr is held until exec_done.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   PCSrc, JALR_Src       next-PC select (JALR_Src has priority), sampled on exec_done
//   ImmExt, ALUResult     PC-relative offset / register jump target
//   exec_done             one-cycle retire strobe for the current instr
//   imem_req, imem_addr   instruction memory request and word address
//   imem_ready, imem_rdata instruction memory response
//   instr, pc, pc_plus4   decoder-facing instruction, its address and address+4
//   instr_valid           instr is decodable
//   misalign_err          sticky: a retired instruction produced a misaligned next PC
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic        JALR_Src,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    input  logic        exec_done,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        take_resp;   // accept the memory response this cycle
    logic        retire;      // current instruction retires this cycle
    logic [31:0] next_pc;
    logic        next_pc_ok;

    // JALR clears bit 0 of the target, so the LSB of ALUResult never matters.
    logic        unused_alu_lsb;
    assign unused_alu_lsb = ALUResult[0];

    // PC arithmetic wraps naturally at 32 bits.
    assign pc_plus4   = pc + 32'd4;
    assign imem_addr  = pc;

    always_comb begin
        next_pc = pc_plus4;
        if (JALR_Src) begin
            next_pc = {ALUResult[31:1], 1'b0};
        end else if (PCSrc) begin
            next_pc = pc + ImmExt;
        end
    end

    assign next_pc_ok = (next_pc[1:0] == 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        take_resp = 1'b0;
        retire    = 1'b0;
        case (state)
            FETCH: begin
                // Request is masked during reset so nothing is issued before release.
                // exec_done is deliberately not looked at here.
                imem_req = !rst;
                if (imem_ready && !rst) begin
                    take_resp = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (exec_done && !rst) begin
                    retire    = 1'b1;
                    state_nxt = next_pc_ok ? FETCH : HALT;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // PC / instruction / status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            instr        <= NOP_INSTR;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else if (take_resp) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
        end else if (retire) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            if (next_pc_ok) begin
                pc <= next_pc;
            end else begin
                // PC stays on the offending instruction for post-mortem.
                misalign_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle vectors followed by
// hand-written sequences for halt, reset-in-flight and late responses.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        PCSrc;
    logic        JALR_Src;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;
    logic        exec_done;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .PCSrc        (PCSrc),
        .JALR_Src     (JALR_Src),
        .ImmExt       (ImmExt),
        .ALUResult    (ALUResult),
        .exec_done    (exec_done),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid),
        .misalign_err (misalign_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        ed;
        logic        psrc;
        logic        jalr;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_vld;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic ed, input logic ps, input logic jr,
                       input logic [31:0] imm, input logic [31:0] alu,
                       input logic rdy, input logic [31:0] rd,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic [31:0] e_instr, input logic [31:0] e_pc,
                       input logic e_vld, input logic e_err);
        vec_t v;
        v.rst = r;  v.ed = ed; v.psrc = ps; v.jalr = jr;
        v.imm = imm; v.alu = alu; v.rdy = rdy; v.rdata = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr;
        v.e_pc = e_pc; v.e_vld = e_vld; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ed, input logic ps, input logic jr,
                         input logic [31:0] imm, input logic [31:0] alu,
                         input logic rdy, input logic [31:0] rd);
        rst = r; exec_done = ed; PCSrc = ps; JALR_Src = jr;
        ImmExt = imm; ALUResult = alu; imem_ready = rdy; imem_rdata = rd;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic [31:0] e_instr, input logic [31:0] e_pc,
                           input logic e_vld, input logic e_err);
        chk({tag, ".imem_req"},     {31'd0, imem_req},     {31'd0, e_req});
        chk({tag, ".imem_addr"},    imem_addr,             e_addr);
        chk({tag, ".instr"},        instr,                 e_instr);
        chk({tag, ".pc"},           pc,                    e_pc);
        chk({tag, ".pc_plus4"},     pc_plus4,              e_pc + 32'd4);
        chk({tag, ".instr_valid"},  {31'd0, instr_valid},  {31'd0, e_vld});
        chk({tag, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, e_err});
    endtask

    initial begin
        // Per-cycle vectors: inputs held across one rising edge, outputs checked after it.
        //   rst ed ps jr imm            alu            rdy rdata          req addr           instr          pc             vld err
        add(0, 0, 0, 0, 32'h0,         32'h0,         1, 32'h0000_0513, 0, 32'h0,         32'h0000_0513, 32'h0,         1, 0); // reset release, immediate response
        add(0, 1, 0, 0, 32'h0,         32'h0,         0, 32'h0,         1, 32'h4,         NOP,           32'h4,         0, 0); // sequential step
        add(0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h0,         1, 32'h4,         NOP,           32'h4,         0, 0); // response delayed 1
        add(0, 1, 1, 0, 32'h100,       32'h0,         0, 32'h0,         1, 32'h4,         NOP,           32'h4,         0, 0); // delayed 2, exec_done ignored
        add(0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h0,         1, 32'h4,         NOP,           32'h4,         0, 0); // delayed 3
        add(0, 1, 0, 0, 32'h0,         32'h0,         1, 32'h00A0_0093, 0, 32'h4,         32'h00A0_0093, 32'h4,         1, 0); // response + coincident exec_done
        add(0, 0, 0, 0, 32'h0,         32'h0,         1, 32'hDEAD_BEEF, 0, 32'h4,         32'h00A0_0093, 32'h4,         1, 0); // VALID ignores imem_ready
        add(0, 1, 1, 0, 32'hFC,        32'h0,         0, 32'h0,         1, 32'h100,       NOP,           32'h100,       0, 0); // branch forward
        add(0, 0, 0, 0, 32'h0,         32'h0,         1, 32'h0000_0063, 0, 32'h100,       32'h0000_0063, 32'h100,       1, 0);
        add(0, 1, 1, 0, 32'hFFFF_FFF0, 32'h0,         0, 32'h0,         1, 32'hF0,        NOP,           32'hF0,        0, 0); // branch backward
        add(0, 0, 0, 0, 32'h0,         32'h0,         1, 32'h0000_8067, 0, 32'hF0,        32'h0000_8067, 32'hF0,        1, 0);
        add(0, 1, 1, 1, 32'h4,         32'h201,       0, 32'h0,         1, 32'h200,       NOP,           32'h200,       0, 0); // JALR wins over PCSrc, LSB cleared
        add(0, 0, 0, 0, 32'h0,         32'h0,         1, 32'h0010_0093, 0, 32'h200,       32'h0010_0093, 32'h200,       1, 0);
        add(0, 1, 0, 1, 32'h0,         32'hFFFF_FFFD, 0, 32'h0,         1, 32'hFFFF_FFFC, NOP,           32'hFFFF_FFFC, 0, 0); // jump to top word
        add(0, 0, 0, 0, 32'h0,         32'h0,         1, 32'h0000_0513, 0, 32'hFFFF_FFFC, 32'h0000_0513, 32'hFFFF_FFFC, 1, 0);
        add(0, 1, 0, 0, 32'h0,         32'h0,         0, 32'h0,         1, 32'h0,         NOP,           32'h0,         0, 0); // wrap to 0, no error
        add(0, 0, 0, 0, 32'h0,         32'h0,         1, 32'h0020_0113, 0, 32'h0,         32'h0020_0113, 32'h0,         1, 0);
        add(0, 1, 1, 0, 32'h10,        32'h0,         0, 32'h0,         1, 32'h10,        NOP,           32'h10,        0, 0);
        add(0, 0, 0, 0, 32'h0,         32'h0,         1, 32'h0000_0463, 0, 32'h10,        32'h0000_0463, 32'h10,        1, 0);
        add(0, 1, 1, 0, 32'h2,         32'h0,         0, 32'h0,         0, 32'h10,        NOP,           32'h10,        0, 1); // misaligned -> HALT

        // Reset
        drive(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        step();
        step();
        chk_all("reset", 0, 32'h0, NOP, 32'h0, 0, 0);
        // First cycle with rst low requests RESET_PC before any edge.
        rst = 1'b0;
        #1;
        chk("release.imem_req",  {31'd0, imem_req}, 32'd1);
        chk("release.imem_addr", imem_addr,         32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ed, vecs[i].psrc, vecs[i].jalr,
                  vecs[i].imm, vecs[i].alu, vecs[i].rdy, vecs[i].rdata);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                    vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_vld, vecs[i].e_err);
        end

        // HALT is sticky: no request for many cycles despite ready/exec_done activity.
        for (int c = 0; c < 12; c++) begin
            drive(0, 1, 0, 0, 32'h0, 32'h0, 1, 32'h0000_0513);
            step();
            chk_all($sformatf("halt%0d", c), 0, 32'h10, NOP, 32'h10, 0, 1);
        end

        // Only reset leaves HALT and clears the error.
        drive(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        step();
        chk_all("halt_rst", 0, 32'h0, NOP, 32'h0, 0, 0);

        drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        step();
        chk_all("refetch", 1, 32'h0, NOP, 32'h0, 0, 0);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0000_0013);
        step();
        chk_all("refetch_rsp", 0, 32'h0, 32'h0000_0013, 32'h0, 1, 0);
        drive(0, 1, 1, 0, 32'h40, 32'h0, 0, 32'h0);
        step();
        chk_all("to_40", 1, 32'h40, NOP, 32'h40, 0, 0);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0000_0593);
        step();
        chk_all("at_40", 0, 32'h40, 32'h0000_0593, 32'h40, 1, 0);

        // Reset while VALID abandons the instruction.
        drive(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        step();
        chk_all("valid_rst", 0, 32'h0, NOP, 32'h0, 0, 0);

        // Ready arriving on the first FETCH cycle after reset is a genuine response.
        drive(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0000_0633);
        step();
        chk_all("late_rdy", 0, 32'h0, 32'h0000_0633, 32'h0, 1, 0);

        // JALR target whose bit 1 is set is misaligned.
        drive(0, 1, 0, 1, 32'h0, 32'h46, 0, 32'h0);
        step();
        chk_all("jalr_mis", 0, 32'h0, NOP, 32'h0, 0, 1);

        // Reset held across a fetch response: no capture while rst is high.
        drive(1, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0000_0733);
        step();
        chk_all("rst_rdy", 0, 32'h0, NOP, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address and must be word-aligned.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (ADDI x0,x0,0), SHALL be the instr value held while no instruction is valid.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 PCSrc  in  1  SHALL select the PC-relative target (pc+ImmExt) when set.
REQ-006 JALR_Src  in  1  SHALL select the register target (ALUResult) when set.
REQ-007 ImmExt  in  32  SHALL be the sign-extended branch/jump offset.
REQ-008 ALUResult  in  32  SHALL be the rs1+imm sum for JALR.
REQ-009 exec_done  in  1  SHALL be a one-cycle pulse from the datapath marking retirement of the current instr; the sampling strobe for REQ-005..008.
REQ-010 imem_req  out  1  SHALL be the instruction-memory request.
REQ-011 imem_addr  out  32  SHALL be the fetch address.
REQ-012 imem_ready  in  1  SHALL indicate imem_rdata is valid this cycle.
REQ-013 imem_rdata  in  32  SHALL be the fetched instruction word.
REQ-014 instr  out  32  SHALL be the instruction presented to the decoder (op=[6:0], funct3=[14:12], funct7_5=[30]).
REQ-015 pc / pc_plus4  out  32 each  SHALL be the address of instr and that address +4.
REQ-016 instr_valid  out  1  SHALL mark instr as decodable.
REQ-017 misalign_err  out  1  SHALL be a sticky flag for a misaligned next-PC.

Function
REQ-018 The FSM SHALL have exactly three states: FETCH, VALID, HALT.
REQ-019 In FETCH: imem_req=1 and imem_addr=pc, both held stable until imem_ready=1; exec_done is ignored.
REQ-020 When imem_ready=1 in FETCH: instr<=imem_rdata, instr_valid<=1, next state VALID; minimum latency is imem_req rising to instr_valid high in 1 cycle.
REQ-021 In VALID: imem_req=0, instr/pc held stable, imem_ready ignored; wait for exec_done.
REQ-022 On exec_done in VALID: next_pc = JALR_Src ? {ALUResult[31:1],1'b0} : PCSrc ? pc+ImmExt : pc+4.
REQ-023 JALR_Src SHALL take priority over PCSrc when both are set.
REQ-024 All PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 with no error.
REQ-025 If next_pc[1:0]==0: pc<=next_pc, instr<=NOP_INSTR, instr_valid<=0, next state FETCH (request asserted the following cycle).
REQ-026 If next_pc[1:0]!=0: pc unchanged, misalign_err<=1, instr_valid<=0, instr<=NOP_INSTR, next state HALT.
REQ-027 HALT SHALL be left only by reset: imem_req=0, instr_valid=0.
REQ-028 pc_plus4 SHALL always equal pc+4 combinationally.
REQ-029 An exec_done pulse arriving in the same cycle that FETCH receives imem_ready SHALL be ignored.

Reset
REQ-030 While rst=1: pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, imem_req=0, misalign_err=0, state<=FETCH.
REQ-031 The first cycle with rst=0 SHALL assert imem_req with imem_addr=RESET_PC.
REQ-032 rst asserted mid-fetch or in VALID/HALT SHALL abandon the outstanding request and apply REQ-030 on the next edge; a late imem_ready is then treated as a new fetch response only in FETCH.

Verification
REQ-033 Reset release, imem_ready same cycle, rdata=32'h0000_0513 -> next cycle instr_valid=1, instr=32'h0000_0513, pc=0, pc_plus4=4.
REQ-034 imem_ready delayed 3 cycles -> imem_req=1, imem_addr constant 3 cycles, instr_valid stays 0 until the response.
REQ-035 pc=0x100, exec_done with PCSrc=1, ImmExt=32'hFFFF_FFF0 -> pc=0xF0 and imem_addr=0xF0 the next cycle; with PCSrc=1, JALR_Src=1, ALUResult=0x201 -> pc=0x200.
REQ-036 exec_done with JALR_Src=0, PCSrc=1, ImmExt=2 at pc=0x10 -> misalign_err=1, state HALT, imem_req remains 0 for 10+ cycles until rst.
REQ-037 pc=32'hFFFF_FFFC, exec_done with sequential step -> pc=0, no error; rst pulse while in VALID -> pc=RESET_PC, instr_valid=0 the next cycle.
